// File: rtl/alu_exec_if.sv
// Execute-stage bus: decoded op and operands in, registered result, strobes and flags out.
interface alu_exec_if #(parameter int W = 16);
  logic         in_valid;
  logic [3:0]   alucontrol;
  logic [4:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         resume;
  logic         out_valid;
  logic [W-1:0] result;
  logic         result_we;
  logic         br_taken;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         halted;

  modport master (
    output in_valid, alucontrol, op, a, b, resume,
    input  out_valid, result, result_we, br_taken, flag_z, flag_n, flag_c, halted
  );

  modport slave (
    input  in_valid, alucontrol, op, a, b, resume,
    output out_valid, result, result_we, br_taken, flag_z, flag_n, flag_c, halted
  );
endinterface

// File: rtl/alu_exec.sv
// Single-cycle execute stage: ALU ops, Z/N/C flag register, branch resolve and run/halt FSM.
module alu_exec #(
  parameter int W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_exec_if.slave bus
);

  localparam logic [3:0] C_NOP  = 4'b0000, C_ADD  = 4'b0001, C_SUB  = 4'b0010,
                         C_AND  = 4'b0011, C_OR   = 4'b0100, C_XOR  = 4'b0101,
                         C_SLL  = 4'b0110, C_SRL  = 4'b0111, C_SLA  = 4'b1000,
                         C_SRA  = 4'b1001, C_ADDC = 4'b1010, C_SUBC = 4'b1011,
                         C_CMP  = 4'b1100, C_LDIH = 4'b1101, C_BR   = 4'b1110,
                         C_IDLE = 4'b1111;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         we;
    logic         br;
    logic         upd_zn;
    logic         upd_c;
    logic         c;
    logic         halt;
  } exec_t;

  state_t       state;
  exec_t        ex;
  logic         accept;
  logic [W-1:0] opb;
  logic         cin;
  logic [W:0]   sum;
  logic [W:0]   sh;
  logic signed [W:0] sra_src;
  logic [3:0]   amt;
  logic         amt_big;

  logic         out_valid_q, result_we_q, br_taken_q, halted_q;
  logic         flag_z_q, flag_n_q, flag_c_q;
  logic [W-1:0] result_q;

  assign accept  = bus.in_valid && (state == RUN);
  assign amt     = bus.b[3:0];
  assign amt_big = int'(amt) >= W;
  assign sra_src = {bus.a, 1'b0};

  // One shared W+1 adder; the carry-in and operand inversion select ADD/SUB/ADDC/SUBC/CMP.
  always_comb begin
    opb = bus.b;
    cin = 1'b0;
    case (bus.alucontrol)
      C_SUB, C_CMP: begin opb = ~bus.b; cin = 1'b1;     end
      C_ADDC:       begin opb = bus.b;  cin = flag_c_q; end
      C_SUBC:       begin opb = ~bus.b; cin = flag_c_q; end
      default:      ;
    endcase
    sum = {1'b0, bus.a} + {1'b0, opb} + {{W{1'b0}}, cin};
  end

  always_comb begin
    ex  = '0;
    sh  = '0;
    case (bus.alucontrol)
      C_ADD, C_SUB, C_ADDC, C_SUBC, C_CMP: begin
        ex.res    = sum[W-1:0];
        ex.c      = sum[W];
        ex.we     = (bus.alucontrol != C_CMP);
        ex.upd_zn = 1'b1;
        ex.upd_c  = 1'b1;
      end
      C_AND, C_OR, C_XOR: begin
        ex.res    = (bus.alucontrol == C_AND) ? (bus.a & bus.b) :
                    (bus.alucontrol == C_OR)  ? (bus.a | bus.b) : (bus.a ^ bus.b);
        ex.we     = 1'b1;
        ex.upd_zn = 1'b1;
      end
      C_SLL, C_SLA: begin
        sh        = {1'b0, bus.a} << amt;
        ex.res    = amt_big ? '0 : sh[W-1:0];
        ex.c      = amt_big ? 1'b0 : sh[W];
        ex.we     = 1'b1;
        ex.upd_zn = 1'b1;
        ex.upd_c  = (amt != 4'd0);
      end
      C_SRL, C_SRA: begin
        // Extra LSB below the operand catches the last bit shifted out.
        if (bus.alucontrol == C_SRA) sh = sra_src >>> amt;
        else                         sh = {bus.a, 1'b0} >> amt;
        ex.we     = 1'b1;
        ex.upd_zn = 1'b1;
        ex.upd_c  = (amt != 4'd0);
        if (amt_big) begin
          ex.res = (bus.alucontrol == C_SRA) ? {W{bus.a[W-1]}} : '0;
          ex.c   = (bus.alucontrol == C_SRA) ? bus.a[W-1] : 1'b0;
        end else begin
          ex.res = sh[W:1];
          ex.c   = sh[0];
        end
      end
      C_LDIH: begin
        ex.res = bus.a + {bus.b[W/2-1:0], {(W/2){1'b0}}};
        ex.we  = 1'b1;
      end
      C_BR: begin
        case (bus.op)
          5'b10100: ex.br = flag_z_q;
          5'b10101: ex.br = !flag_z_q;
          5'b10110: ex.br = flag_c_q;
          5'b10111: ex.br = !flag_c_q;
          5'b11000: ex.br = flag_n_q;
          5'b11001: ex.br = !flag_n_q;
          default:  ex.br = 1'b0;
        endcase
      end
      C_NOP:   ex.halt = (bus.op == OP_HALT);
      C_IDLE:  ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_we_q <= 1'b0;
      br_taken_q  <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        result_we_q <= ex.we;
        br_taken_q  <= ex.br;
        // Non-writing ops (CMP, branches, NOP) leave the visible result untouched.
        if (ex.we) result_q <= ex.res;
        if (ex.upd_zn) begin
          flag_z_q <= (ex.res == '0);
          flag_n_q <= ex.res[W-1];
        end
        if (ex.upd_c) flag_c_q <= ex.c;
      end
      case (state)
        RUN: if (accept && ex.halt) begin
          state    <= HALTED;
          halted_q <= 1'b1;
        end
        HALTED: if (bus.resume) begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
        default: begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_we = result_we_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.halted    = halted_q;

endmodule
